// File: rtl/booth_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier: FSM states,
// digit-select encoding and the digit-count helper.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_ZERO   = 3'd0,
    SEL_POS_A  = 3'd1,
    SEL_POS_2A = 3'd2,
    SEL_NEG_2A = 3'd3,
    SEL_NEG_A  = 3'd4
  } digit_sel_t;

  // Digits needed to cover a WIDTH-bit operand extended by two guard bits
  function automatic int unsigned booth_digits(input int unsigned width);
    return width / 2 + 1;
  endfunction

  // Radix-4 Booth recoding of one overlapping bit triple (b2,b1,b0)
  function automatic digit_sel_t booth_decode(input logic [2:0] digit);
    digit_sel_t sel;
    case (digit)
      3'b001, 3'b010: sel = SEL_POS_A;
      3'b011:         sel = SEL_POS_2A;
      3'b100:         sel = SEL_NEG_2A;
      3'b101, 3'b110: sel = SEL_NEG_A;
      default:        sel = SEL_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_sel.sv
// Combinational partial-product selector: one Booth digit applied to the
// (already shifted) multiplicand gives 0, +-A or +-2A.
module booth_sel
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]         i_digit,
  input  logic [2*WIDTH-1:0] i_a,
  output logic [2*WIDTH-1:0] o_pp_c
);

  localparam int unsigned PW = 2 * WIDTH;

  digit_sel_t      w_sel;
  logic [PW-1:0]   w_a2;

  assign w_sel = booth_decode(i_digit);
  assign w_a2  = {i_a[PW-2:0], 1'b0};

  always_comb begin
    o_pp_c = '0;
    case (w_sel)
      SEL_POS_A:  o_pp_c = i_a;
      SEL_POS_2A: o_pp_c = w_a2;
      SEL_NEG_2A: o_pp_c = ~w_a2 + PW'(1);
      SEL_NEG_A:  o_pp_c = ~i_a + PW'(1);
      default:    o_pp_c = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Optional macro BOOTH_MUL_EARLY_EXIT_EN ends BUSY once the remaining multiplier bits are uniform.
module booth_mul_iter
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned BW = WIDTH + 3;
  localparam int unsigned N  = booth_digits(WIDTH);
  localparam int unsigned CW = $clog2(N);

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_a;
  logic [BW-1:0]   r_b;
  logic [CW-1:0]   r_cnt;
  logic            r_out_valid;

  logic            w_accept;
  logic            w_last;
  logic [PW-1:0]   w_pp;
  logic [PW-1:0]   w_a_ext;
  logic [BW-1:0]   w_b_ext;
  logic [BW-1:0]   w_b_next;

  assign in_ready   = (r_state == ST_IDLE) & ~flush;
  assign w_accept   = in_valid & in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_acc;

  // Operand extension; B also carries the implicit zero below its LSB
  assign w_a_ext  = {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a};
  assign w_b_ext  = {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
  assign w_b_next = {{2{r_b[BW-1]}}, r_b[BW-1:2]};

  booth_sel #(.WIDTH(WIDTH)) u_sel (
    .i_digit (r_b[2:0]),
    .i_a     (r_a),
    .o_pp_c  (w_pp)
  );

  always_comb begin
    w_last = (r_cnt == CW'(N - 1));
`ifdef BOOTH_MUL_EARLY_EXIT_EN
    if ((&w_b_next) || (~|w_b_next)) begin
      w_last = 1'b1;
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_BUSY;
      ST_BUSY: begin
        if (flush)       w_state_next = ST_IDLE;
        else if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (flush || out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: accumulate one shifted partial product per BUSY cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_state_next == ST_DONE);
      if (w_accept) begin
        r_acc <= '0;
        r_a   <= w_a_ext;
        r_b   <= w_b_ext;
        r_cnt <= '0;
      end else if ((r_state == ST_BUSY) && !flush) begin
        r_acc <= r_acc + w_pp;
        r_a   <= {r_a[PW-3:0], 2'b00};
        r_b   <= w_b_next;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/booth_mul_iter.md
BOOTH_MUL_ITER -- requirements
Module: booth_mul_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; even, >= 4.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
REQ-004 SHALL have port flush  input  1  abort in-flight op; result discarded.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port in_signed  input  1  1: two's-complement operands; 0: unsigned.
REQ-008 SHALL have ports in_a, in_b  input  WIDTH  multiplicand, multiplier.
REQ-009 SHALL have port out_valid  output  1  product available.
REQ-010 SHALL have port out_ready  input  1  consumer takes product.
REQ-011 SHALL have port out_result  output  2*WIDTH  product.

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE: IDLE->BUSY on accept; BUSY->DONE after last digit; DONE->IDLE on out_valid & out_ready.
REQ-013 SHALL drive in_ready = (state==IDLE) & !flush; accept = in_valid & in_ready.
REQ-014 SHALL on accept latch A extended to 2*WIDTH bits and B extended to WIDTH+2 bits, sign-extended if in_signed, else zero-extended, plus implicit 0 below B's LSB.
REQ-015 SHALL retire one radix-4 Booth digit per BUSY cycle, N = WIDTH/2+1 digits, LSB first; digit (b2,b1,b0) selects 0,+A,+A,+2A,-2A,-A,-A,0 for 000..111.
REQ-016 SHALL add the selected partial product shifted by 2*i into a 2*WIDTH accumulator, modulo 2^(2*WIDTH).
REQ-017 SHALL, with fixed latency, assert out_valid in the cycle N+1 after the accept cycle (N BUSY cycles).
REQ-018 SHALL hold out_result and out_valid stable while out_valid & !out_ready; out_result is don't-care when out_valid=0.
REQ-019 SHALL on flush in BUSY or DONE return to IDLE next cycle with out_valid=0; flush dominates out_ready and in_valid in the same cycle.
REQ-020 SHALL not accept a new op in the same cycle a result is consumed (IDLE required first).

Reset
REQ-021 SHALL on reset go to IDLE, clear accumulator and operand registers, out_valid=0, out_result=0; in_ready=1 from first cycle after reset deasserts.
REQ-022 SHALL let reset mid-operation discard the op with no out_valid.

Configuration
REQ-023 SHALL honour macro BOOTH_MUL_EARLY_EXIT_EN: when defined, BUSY->DONE as soon as the unprocessed multiplier bits including the overlap bit are all 0 or all 1 (minimum one BUSY cycle), result identical; when undefined, latency is always N BUSY cycles.

Structure
REQ-024 SHALL place the state enum, Booth digit-select typedef and digit-count constant (WIDTH/2+1) in shared package booth_pkg.
REQ-025 SHALL instantiate sub-module booth_sel (parametrised by WIDTH; digit + A -> partial product 0/+-A/+-2A) once, combinationally.

Verification (WIDTH=32, N=17)
REQ-026 SHALL cover signed -3 x 7 -> out_result 64'hFFFF_FFFF_FFFF_FFEB, out_valid in cycle 18 after accept (macro undefined).
REQ-027 SHALL cover unsigned 32'hFFFF_FFFF x 32'hFFFF_FFFF -> 64'hFFFF_FFFE_0000_0001; signed 32'h8000_0000 x 32'h8000_0000 -> 64'h4000_0000_0000_0000.
REQ-028 SHALL cover out_ready held 0 for 5 cycles after out_valid -> out_result unchanged, in_ready=0 throughout; consumed on sixth cycle, in_ready=1 next cycle.
REQ-029 SHALL cover flush in 5th BUSY cycle -> no out_valid, in_ready=1 next cycle; following op 6 x 7 unsigned -> 42.
REQ-030 SHALL cover, with BOOTH_MUL_EARLY_EXIT_EN, signed 5 x 3 -> 15 with out_valid in cycle 3 after accept; 0 x 0 -> 0 after one BUSY cycle.
REQ-031 SHALL cover reset asserted during BUSY -> out_valid=0, out_result=0, state IDLE after the reset cycle.
